// File: rtl/btn_debounce_pkg.sv
// Shared types and 50 MHz default timing constants for the push-button debouncer.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } btn_state_t;

    localparam int DEF_STABLE_CYCLES = 500_000;     // 10 ms
    localparam int DEF_REPEAT_DELAY  = 25_000_000;  // 500 ms
    localparam int DEF_REPEAT_PERIOD = 5_000_000;   // 100 ms

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_debounce_sync_2ff.sv
// Two-flop synchronizer for one asynchronous level; the reset value is the
// input's idle level so no false edge is seen when reset is released.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_in,
    output logic q_out
);

    logic meta_q;
    logic sync_q;

    // NOTE: non-blocking assignments let both flops sample on the same edge,
    // giving a real two-stage shift instead of a single wire-through flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_in;
            sync_q <= meta_q;
        end
    end

    assign q_out = sync_q;

endmodule

// File: rtl/btn_debounce.sv
// Push-button debouncer: synchronizer, four-state accept FSM, registered strobes.
// Define BTN_DEBOUNCE_REPEAT_EN to add the hold counter and auto-repeat strobe.
module btn_debounce
    import btn_pkg::*;
#(
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int ACTIVE_LOW    = 1,
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic CLOCK_50,
    input  logic RESET,
    input  logic BTN_RAW,
    output logic BTN_LEVEL,
    output logic PRESS_PULSE,
    output logic RELEASE_PULSE,
    output logic REPEAT_PULSE
);

    localparam int                CNT_W    = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic              RAW_IDLE = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    logic raw_sync;
    logic btn_s;

    sync_2ff #(
        .RESET_VAL (RAW_IDLE)
    ) u_sync (
        .clk   (CLOCK_50),
        .rst   (RESET),
        .d_in  (BTN_RAW),
        .q_out (raw_sync)
    );

    assign btn_s = (ACTIVE_LOW != 0) ? ~raw_sync : raw_sync;

    btn_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;

    // NOTE: every signal gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (btn_s) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!btn_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q < CNT_LAST) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!btn_s) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (btn_s) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q < CNT_LAST) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Outputs are decoded from the next state so they land in the same
        // cycle as the state they describe.
        level_d   = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
        press_d   = (state_q == PRESS_WAIT) && (state_d == PRESSED);
        release_d = (state_q == RELEASE_WAIT) && (state_d == IDLE);
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign BTN_LEVEL     = level_q;
    assign PRESS_PULSE   = press_q;
    assign RELEASE_PULSE = release_q;

`ifdef BTN_DEBOUNCE_REPEAT_EN
    localparam int               HOLD_W      = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);
    localparam logic [HOLD_W-1:0] DELAY_LAST  = HOLD_W'(REPEAT_DELAY - 1);
    localparam logic [HOLD_W-1:0] PERIOD_LAST = HOLD_W'(REPEAT_PERIOD - 1);

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              armed_q, armed_d;
    logic              repeat_q, repeat_d;

    // Hold time restarts on every entry to PRESSED; after the first strobe
    // the shorter period threshold takes over until the button leaves PRESSED.
    always_comb begin
        hold_d   = '0;
        armed_d  = 1'b0;
        repeat_d = 1'b0;
        if ((state_q == PRESSED) && (state_d == PRESSED)) begin
            armed_d = armed_q;
            if (hold_q == (armed_q ? PERIOD_LAST : DELAY_LAST)) begin
                repeat_d = 1'b1;
                hold_d   = '0;
                armed_d  = 1'b1;
            end else begin
                hold_d = hold_q + HOLD_W'(1);
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            hold_q   <= '0;
            armed_q  <= 1'b0;
            repeat_q <= 1'b0;
        end else begin
            hold_q   <= hold_d;
            armed_q  <= armed_d;
            repeat_q <= repeat_d;
        end
    end

    assign REPEAT_PULSE = repeat_q;
`else
    assign REPEAT_PULSE = 1'b0;
`endif

endmodule
